// File: rtl/dac_output_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_output_conditioner_if
// Purpose  : Bundles the command bus, sample stream and conditioned outputs
//            of dac_output_conditioner.
// Signals  : cmd_trig_in/cmd_addr_in/cmd_data_in  shared PC command bus
//            cmd_data_out                         registered read data
//            data0_in/data1_in/data_valid_in      requested samples
//            DAC0_out/DAC1_out                    conditioned samples
//            clamp_out/fault_out/state_out        status
// Modports : master drives commands and samples, slave is the conditioner.
// Revision : 1.0  initial release
// ============================================================================
interface dac_output_conditioner_if;
    logic        cmd_trig_in;
    logic [15:0] cmd_addr_in;
    logic [15:0] cmd_data_in;
    logic [15:0] cmd_data_out;
    logic [15:0] data0_in;
    logic [15:0] data1_in;
    logic        data_valid_in;
    logic [15:0] DAC0_out;
    logic [15:0] DAC1_out;
    logic [1:0]  clamp_out;
    logic        fault_out;
    logic [1:0]  state_out;

    modport master (
        output cmd_trig_in, cmd_addr_in, cmd_data_in,
        output data0_in, data1_in, data_valid_in,
        input  cmd_data_out, DAC0_out, DAC1_out, clamp_out, fault_out, state_out
    );

    modport slave (
        input  cmd_trig_in, cmd_addr_in, cmd_data_in,
        input  data0_in, data1_in, data_valid_in,
        output cmd_data_out, DAC0_out, DAC1_out, clamp_out, fault_out, state_out
    );
endinterface
`default_nettype wire

// File: rtl/dac_output_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : dac_output_conditioner
// Purpose  : Two-channel window clamp plus slew limiter feeding the AD9783
//            DAC controller. Outputs ramp to 0 on stop or when the input
//            stream stalls (watchdog), and the block is programmed over the
//            shared PC command bus (writes on page CMD_BASE, reads on
//            page CMD_BASE+1).
// Ports    : clk_in  system clock, rising edge
//            rst_in  synchronous active-high reset
//            bus     dac_output_conditioner_if.slave (commands, samples,
//                    conditioned outputs, status)
// Options  : DAC_COND_READBACK_EN  when defined, reads return the register
//            map (index 6 = state, index 7 = fault); otherwise cmd_data_out
//            is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module dac_output_conditioner #(
    parameter logic [7:0]  CMD_BASE     = 8'h22,
    parameter logic [15:0] SLEW_DEFAULT = 16'h0100,
    parameter int          WDOG_CYCLES  = 1000
) (
    input wire clk_in,
    input wire rst_in,
    dac_output_conditioner_if.slave bus
);

    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RAMPDN  = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    // ---------------------------------------------------------------- decode
    logic [7:0] w_page;
    logic [3:0] w_idx;
    logic       w_wr;
    logic       w_clr;
    logic       w_unused_addr;

    assign w_page        = bus.cmd_addr_in[15:8];
    assign w_idx         = bus.cmd_addr_in[3:0];
    assign w_wr          = bus.cmd_trig_in && (w_page == CMD_BASE);
    assign w_clr         = w_wr && (w_idx == 4'd5) && bus.cmd_data_in[1];
    assign w_unused_addr = ^bus.cmd_addr_in[7:4];

    // ------------------------------------------------------------- registers
    logic signed [15:0] r_max0, r_min0, r_max1, r_min1;
    logic [15:0]        r_step;
    logic               r_run;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_max0 <= 16'sh7FFF;
            r_min0 <= -16'sh8000;
            r_max1 <= 16'sh7FFF;
            r_min1 <= -16'sh8000;
            r_step <= SLEW_DEFAULT;
            r_run  <= 1'b0;
        end else if (w_wr) begin
            case (w_idx)
                4'd0:    r_max0 <= bus.cmd_data_in;
                4'd1:    r_min0 <= bus.cmd_data_in;
                4'd2:    r_max1 <= bus.cmd_data_in;
                4'd3:    r_min1 <= bus.cmd_data_in;
                4'd4:    r_step <= bus.cmd_data_in;
                4'd5:    r_run  <= bus.cmd_data_in[0];
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------- stage 1 clamp
    // The min test has priority, so an inverted window (min>max) yields min
    // for every sample below it.
    function automatic logic signed [15:0] f_clamp(input logic signed [15:0] x,
                                                   input logic signed [15:0] mn,
                                                   input logic signed [15:0] mx);
        if (x < mn)      return mn;
        else if (x > mx) return mx;
        else             return x;
    endfunction

    logic signed [15:0] w_c0, w_c1;
    logic signed [15:0] r_tgt0, r_tgt1;
    logic [1:0]         r_clamp;

    assign w_c0 = f_clamp(bus.data0_in, r_min0, r_max0);
    assign w_c1 = f_clamp(bus.data1_in, r_min1, r_max1);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tgt0  <= '0;
            r_tgt1  <= '0;
            r_clamp <= 2'b00;
        end else if (bus.data_valid_in) begin
            r_tgt0  <= w_c0;
            r_tgt1  <= w_c1;
            r_clamp <= {w_c1 != bus.data1_in, w_c0 != bus.data0_in};
        end
    end

    // ---------------------------------------------------------- stage 2 slew
    // 17-bit signed difference covers the full span of two 16-bit values and
    // -step for any step, so neither the compare nor the update can wrap.
    function automatic logic signed [15:0] f_slew(input logic signed [15:0] goal,
                                                  input logic signed [15:0] cur,
                                                  input logic [15:0]        step);
        logic signed [16:0] d;
        logic signed [16:0] s;
        logic signed [16:0] n;
        d = {goal[15], goal} - {cur[15], cur};
        s = {1'b0, step};
        if (d > s)       n = {cur[15], cur} + s;
        else if (d < -s) n = {cur[15], cur} - s;
        else             n = {goal[15], goal};
        return n[15:0];
    endfunction

    state_t             r_state;
    logic signed [15:0] w_goal0, w_goal1;
    logic signed [15:0] r_dac0, r_dac1;

    assign w_goal0 = (r_state == S_RUN) ? r_tgt0 : 16'sd0;
    assign w_goal1 = (r_state == S_RUN) ? r_tgt1 : 16'sd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dac0 <= '0;
            r_dac1 <= '0;
        end else begin
            r_dac0 <= f_slew(w_goal0, r_dac0, r_step);
            r_dac1 <= f_slew(w_goal1, r_dac1, r_step);
        end
    end

    // ------------------------------------------------------ FSM and watchdog
    logic [c_wdog_w-1:0] r_wdog;
    logic                r_fault;
    logic                w_timeout;

    // Fires on the WDOG_CYCLES-th consecutive cycle without data_valid_in.
    assign w_timeout = (r_state == S_RUN) && !bus.data_valid_in && (r_wdog == c_wdog_last);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
            r_fault <= 1'b0;
        end else begin
            // Timeout takes precedence over a simultaneous clear.
            if (w_timeout)  r_fault <= 1'b1;
            else if (w_clr) r_fault <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (r_run && !r_fault) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_timeout || !r_run) begin
                        r_state <= S_RAMPDN;
                        r_wdog  <= '0;
                    end else if (bus.data_valid_in) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + c_wdog_w'(1);
                    end
                end
                S_RAMPDN: begin
                    r_wdog <= '0;
                    if (r_dac0 == 16'sd0 && r_dac1 == 16'sd0) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wdog  <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- readback
`ifdef DAC_COND_READBACK_EN
    logic        w_rd;
    logic [15:0] w_rdata;
    logic [15:0] r_rdata;

    assign w_rd = bus.cmd_trig_in && (w_page == CMD_BASE + 8'd1);

    always_comb begin
        w_rdata = 16'h0000;
        case (w_idx)
            4'd0:    w_rdata = r_max0;
            4'd1:    w_rdata = r_min0;
            4'd2:    w_rdata = r_max1;
            4'd3:    w_rdata = r_min1;
            4'd4:    w_rdata = r_step;
            4'd5:    w_rdata = {15'b0, r_run};
            4'd6:    w_rdata = {14'b0, r_state};
            4'd7:    w_rdata = {15'b0, r_fault};
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)    r_rdata <= 16'h0000;
        else if (w_rd) r_rdata <= w_rdata;
    end

    assign bus.cmd_data_out = r_rdata;
`else
    assign bus.cmd_data_out = 16'h0000;
`endif

    assign bus.DAC0_out  = r_dac0;
    assign bus.DAC1_out  = r_dac1;
    assign bus.clamp_out = r_clamp;
    assign bus.fault_out = r_fault;
    assign bus.state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dac_output_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_output_conditioner
// Purpose  : Directed self-checking bench for dac_output_conditioner:
//            reset state, slew ramp, clamping, inverted window, watchdog
//            fault/ramp-down/clear, full-scale step, reset mid-ramp and
//            command page decode / readback (DAC_COND_READBACK_EN aware).
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_output_conditioner;

    localparam logic [7:0] c_base = 8'h22;
    localparam int         c_wdog = 1000;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    dac_output_conditioner_if bus ();

    dac_output_conditioner #(
        .CMD_BASE     (c_base),
        .SLEW_DEFAULT (16'h0100),
        .WDOG_CYCLES  (c_wdog)
    ) u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cmd(input logic [15:0] addr, input logic [15:0] data);
        bus.cmd_trig_in = 1'b1;
        bus.cmd_addr_in = addr;
        bus.cmd_data_in = data;
        tick();
        bus.cmd_trig_in = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] data);
        cmd({c_base, 4'h0, idx}, data);
    endtask

`ifdef DAC_COND_READBACK_EN
    localparam bit c_rb = 1'b1;
`else
    localparam bit c_rb = 1'b0;
`endif

    initial begin
        bus.cmd_trig_in   = 1'b0;
        bus.cmd_addr_in   = 16'h0000;
        bus.cmd_data_in   = 16'h0000;
        bus.data0_in      = 16'h0000;
        bus.data1_in      = 16'h0000;
        bus.data_valid_in = 1'b0;

        // Reset state
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_dac0",  bus.DAC0_out, 16'h0000);
        chk("rst_dac1",  bus.DAC1_out, 16'h0000);
        chk("rst_clamp", 16'(bus.clamp_out), 16'h0000);
        chk("rst_fault", 16'(bus.fault_out), 16'h0000);
        chk("rst_state", 16'(bus.state_out), 16'h0000);
        chk("rst_rdata", bus.cmd_data_out, 16'h0000);

        // Slew ramp 0 -> 0x1000 at 0x0100 per clock
        wr(4'd5, 16'h0001);
        bus.data0_in      = 16'h1000;
        bus.data_valid_in = 1'b1;
        tick();
        chk("run_state", 16'(bus.state_out), 16'h0001);
        chk("ramp_0", bus.DAC0_out, 16'h0000);
        tick();
        chk("ramp_1", bus.DAC0_out, 16'h0100);
        repeat (14) tick();
        chk("ramp_15", bus.DAC0_out, 16'h0F00);
        tick();
        chk("ramp_16", bus.DAC0_out, 16'h1000);
        tick();
        chk("ramp_hold", bus.DAC0_out, 16'h1000);
        chk("ramp_noclamp", 16'(bus.clamp_out), 16'h0000);

        // Clamp to max0; a write coinciding with a sample applies to the next one
        bus.data0_in = 16'h7000;
        wr(4'd0, 16'h0800);
        chk("clamp_same_cycle", 16'(bus.clamp_out), 16'h0000);
        tick();
        chk("clamp_hit", 16'(bus.clamp_out), 16'h0001);
        repeat (20) tick();
        chk("clamp_settle", bus.DAC0_out, 16'h0800);
        bus.data0_in = 16'h0400;
        tick();
        chk("clamp_release", 16'(bus.clamp_out), 16'h0000);
        repeat (10) tick();
        chk("dac0_0400", bus.DAC0_out, 16'h0400);

        // Inverted window on channel 1: min wins
        wr(4'd3, 16'h0010);
        wr(4'd2, 16'h0000);
        bus.data1_in = 16'h8000;
        repeat (4) tick();
        chk("inv_dac1", bus.DAC1_out, 16'h0010);
        chk("inv_clamp", 16'(bus.clamp_out), 16'h0002);

        // Watchdog timeout, ramp-down, fault blocks restart
        bus.data_valid_in = 1'b0;
        repeat (c_wdog - 1) tick();
        chk("wd_pre_fault", 16'(bus.fault_out), 16'h0000);
        chk("wd_pre_state", 16'(bus.state_out), 16'h0001);
        tick();
        chk("wd_fault", 16'(bus.fault_out), 16'h0001);
        chk("wd_rampdn", 16'(bus.state_out), 16'h0002);
        chk("wd_dac0_hold", bus.DAC0_out, 16'h0400);
        repeat (3) tick();
        chk("rd_step3", bus.DAC0_out, 16'h0100);
        tick();
        chk("rd_step4", bus.DAC0_out, 16'h0000);
        chk("rd_dac1", bus.DAC1_out, 16'h0000);
        chk("rd_still_rampdn", 16'(bus.state_out), 16'h0002);
        tick();
        chk("rd_idle", 16'(bus.state_out), 16'h0000);
        repeat (3) tick();
        chk("fault_blocks", 16'(bus.state_out), 16'h0000);
        wr(4'd5, 16'h0001);
        tick();
        chk("fault_blocks_run", 16'(bus.state_out), 16'h0000);
        wr(4'd5, 16'h0002);
        chk("fault_cleared", 16'(bus.fault_out), 16'h0000);
        wr(4'd5, 16'h0001);
        tick();
        chk("rerun", 16'(bus.state_out), 16'h0001);

        // Full-scale step with no wrap, latency of two cycles
        wr(4'd0, 16'h7FFF);
        wr(4'd4, 16'hFFFF);
        bus.data0_in      = 16'h7FFF;
        bus.data_valid_in = 1'b1;
        tick();
        tick();
        chk("fs_pos", bus.DAC0_out, 16'h7FFF);
        bus.data0_in = 16'h8000;
        tick();
        chk("fs_lat1", bus.DAC0_out, 16'h7FFF);
        tick();
        chk("fs_neg", bus.DAC0_out, 16'h8000);
        bus.data0_in = 16'h7FFF;
        tick();
        tick();
        chk("fs_pos2", bus.DAC0_out, 16'h7FFF);

        // Reset mid-ramp
        wr(4'd4, 16'h0001);
        bus.data0_in = 16'h0000;
        repeat (3) tick();
        chk("slow_ramp", bus.DAC0_out, 16'h7FFD);
        rst_in = 1'b1;
        tick();
        rst_in            = 1'b0;
        bus.data_valid_in = 1'b0;
        chk("mid_rst_dac0",  bus.DAC0_out, 16'h0000);
        chk("mid_rst_dac1",  bus.DAC1_out, 16'h0000);
        chk("mid_rst_clamp", 16'(bus.clamp_out), 16'h0000);
        chk("mid_rst_state", 16'(bus.state_out), 16'h0000);

        // Command pages: write, read, foreign pages ignored
        cmd(16'h2204, 16'h1234);
        cmd(16'h2304, 16'h0000);
        chk("read_step", bus.cmd_data_out, c_rb ? 16'h1234 : 16'h0000);
        tick();
        tick();
        chk("read_hold", bus.cmd_data_out, c_rb ? 16'h1234 : 16'h0000);
        cmd(16'h2005, 16'h0001);
        cmd(16'h2104, 16'h0000);
        cmd(16'h2004, 16'h5555);
        repeat (3) tick();
        chk("foreign_no_run", 16'(bus.state_out), 16'h0000);
        cmd(16'h2304, 16'h0000);
        chk("foreign_step", bus.cmd_data_out, c_rb ? 16'h1234 : 16'h0000);
        cmd(16'h2300, 16'h0000);
        chk("read_max0", bus.cmd_data_out, c_rb ? 16'h7FFF : 16'h0000);
        cmd(16'h2309, 16'h0000);
        chk("read_idx9", bus.cmd_data_out, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
